// File: rtl/prng_stream.sv
// Fibonacci-LFSR random-word generator: one WIDTH-bit word every STEPS shifts,
// buffered in a DEPTH-entry first-word-fall-through FIFO with sticky status flags.
module prng_stream #(
  parameter int unsigned      WIDTH = 128,
  parameter logic [WIDTH-1:0] TAPS  = 128'hA000_0006_0000_0000_0000_0000_0000_0000,
  parameter int unsigned      STEPS = WIDTH,
  parameter int unsigned      DEPTH = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [WIDTH-1:0]           seed_i,
  input  logic                       ctrl_we,
  input  logic [3:0]                 ctrl_i,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           data_o,
  output logic                       data_valid,
  output logic                       busy,
  output logic                       done,
  output logic                       seed_err,
  output logic                       fifo_full,
  output logic [$clog2(DEPTH+1)-1:0] fifo_count,
  output logic [31:0]                word_cnt
);

  localparam int unsigned CntW   = $clog2(STEPS + 1);
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam int unsigned CountW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {StIdle, StLoad, StRun, StPush} state_e;

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    lfsr_q, lfsr_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic                cont_q, cont_d;
  logic                done_q, done_d;
  logic                seed_err_q, seed_err_d;
  logic [WIDTH-1:0]    mem_q [DEPTH];
  logic [WIDTH-1:0]    mem_d [DEPTH];
  logic [PtrW-1:0]     wptr_q, wptr_d;
  logic [PtrW-1:0]     rptr_q, rptr_d;
  logic [CountW-1:0]   count_q, count_d;
  logic [31:0]         word_cnt_q, word_cnt_d;

  logic fb, full, clr, push, pop;

  assign fb   = ^(lfsr_q & TAPS);
  assign full = (count_q == CountW'(DEPTH));
  assign clr  = ctrl_we & ctrl_i[3];

  always_comb begin
    state_d    = state_q;
    lfsr_d     = lfsr_q;
    cnt_d      = cnt_q;
    cont_d     = cont_q;
    done_d     = done_q;
    seed_err_d = seed_err_q;
    push       = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (ctrl_we && ctrl_i[0]) begin
          done_d     = 1'b0;
          seed_err_d = 1'b0;
          cont_d     = ctrl_i[2];
          cnt_d      = '0;
          state_d    = ctrl_i[1] ? StLoad : StRun;
        end
      end
      StLoad: begin
        if (seed_i == '0) begin
          seed_err_d = 1'b1;
          state_d    = StIdle;
        end else begin
          lfsr_d  = seed_i;
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        lfsr_d = {lfsr_q[WIDTH-2:0], fb};
        cnt_d  = cnt_q + CntW'(1);
        if (cnt_q == CntW'(STEPS - 1)) state_d = StPush;
      end
      StPush: begin
        // A same-cycle pop or clear frees a slot, so a full FIFO need not stall.
        if (!full || rd_en || clr) begin
          push = 1'b1;
          if (cont_q) begin
            cnt_d   = '0;
            state_d = StRun;
          end else begin
            done_d  = 1'b1;
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase

    if (ctrl_we && state_q != StIdle) cont_d = ctrl_i[2];
  end

  always_comb begin
    pop        = rd_en && (count_q != '0) && !clr;
    mem_d      = mem_q;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    count_d    = count_q;
    word_cnt_d = word_cnt_q;

    if (clr) begin
      rptr_d  = wptr_q;
      count_d = '0;
    end
    if (pop) begin
      rptr_d  = rptr_q + PtrW'(1);
      count_d = count_q - CountW'(1);
    end
    if (push) begin
      mem_d[wptr_q] = lfsr_q;
      wptr_d        = wptr_q + PtrW'(1);
      count_d       = count_d + CountW'(1);
      word_cnt_d    = word_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      lfsr_q     <= WIDTH'(1);
      cnt_q      <= '0;
      cont_q     <= 1'b0;
      done_q     <= 1'b0;
      seed_err_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      word_cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      lfsr_q     <= lfsr_d;
      cnt_q      <= cnt_d;
      cont_q     <= cont_d;
      done_q     <= done_d;
      seed_err_q <= seed_err_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
      count_q    <= count_d;
      word_cnt_q <= word_cnt_d;
      mem_q      <= mem_d;
    end
  end

  assign data_valid = (count_q != '0);
  assign data_o     = data_valid ? mem_q[rptr_q] : '0;
  assign fifo_full  = full;
  assign fifo_count = count_q;
  assign busy       = (state_q != StIdle);
  assign done       = done_q;
  assign seed_err   = seed_err_q;
  assign word_cnt   = word_cnt_q;

endmodule
